// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Brief    : Shared types and constants for the instruction/data memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int ADDR_W_DEFAULT = 6;
    localparam int DATA_W_DEFAULT = 128;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_BUSY = 3'd1,
        D_DONE = 3'd2,
        I_BUSY = 3'd3,
        I_DONE = 3'd4
    } arb_state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_D = 1'b0;
    localparam req_id_t REQ_I = 1'b1;

    // Priority holder after a grant: the requester that was not just served.
    function automatic req_id_t other_req(input req_id_t id);
        return (id == REQ_D) ? REQ_I : REQ_D;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_grant.sv
`default_nettype none
// ============================================================================
//  Module   : arb_grant
//  Brief    : Picks the winning requester from the two request levels.
//             ARB_ROUND_ROBIN_EN: contention goes to the pointer's requester;
//             otherwise data always beats instruction.
//  Revision : 1.0 - initial release
// ============================================================================
module arb_grant
    import mem_arb_pkg::*;
(
    input  logic    i_d_req,
    input  logic    i_i_req,
    input  req_id_t i_ptr,
    output req_id_t o_winner
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        o_winner = REQ_I;
        if (i_d_req && i_i_req) begin
            o_winner = i_ptr;
        end else if (i_d_req) begin
            o_winner = REQ_D;
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = i_ptr;

    always_comb begin
        o_winner = REQ_I;
        if (i_d_req) begin
            o_winner = REQ_D;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Shares one block memory between the I-cache and D-cache.
//             Optional macro ARB_ROUND_ROBIN_EN selects round-robin arbitration.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IREAD,
    input  logic [ADDR_W-1:0] IADDRESS,
    output logic [DATA_W-1:0] IREADDATA,
    output logic              IBUSYWAIT,
    input  logic              DREAD,
    input  logic              DWRITE,
    input  logic [ADDR_W-1:0] DADDRESS,
    input  logic [DATA_W-1:0] DWRITEDATA,
    output logic [DATA_W-1:0] DREADDATA,
    output logic              DBUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDRESS,
    output logic [DATA_W-1:0] MEM_WRITEDATA,
    input  logic [DATA_W-1:0] MEM_READDATA,
    input  logic              MEM_BUSYWAIT
);

    arb_state_t        state_q, state_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_writedata_q, mem_writedata_d;
    logic [DATA_W-1:0] ireaddata_q, ireaddata_d;
    logic [DATA_W-1:0] dreaddata_q, dreaddata_d;

    logic    d_req;
    req_id_t ptr;
    req_id_t winner;

    assign d_req = DREAD | DWRITE;

`ifdef ARB_ROUND_ROBIN_EN
    req_id_t ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && (d_req || IREAD)) begin
            ptr_d = other_req(winner);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ptr_q <= REQ_D;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = REQ_D;
`endif

    arb_grant u_arb_grant (
        .i_d_req  (d_req),
        .i_i_req  (IREAD),
        .i_ptr    (ptr),
        .o_winner (winner)
    );

    always_comb begin
        state_d         = state_q;
        mem_read_d      = mem_read_q;
        mem_write_d     = mem_write_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;
        ireaddata_d     = ireaddata_q;
        dreaddata_d     = dreaddata_q;

        case (state_q)
            IDLE: begin
                if (d_req || IREAD) begin
                    if (winner == REQ_D) begin
                        // A simultaneous read is dropped in favour of the write.
                        state_d         = D_BUSY;
                        mem_write_d     = DWRITE;
                        mem_read_d      = ~DWRITE;
                        mem_address_d   = DADDRESS;
                        mem_writedata_d = DWRITEDATA;
                    end else begin
                        state_d       = I_BUSY;
                        mem_read_d    = 1'b1;
                        mem_write_d   = 1'b0;
                        mem_address_d = IADDRESS;
                    end
                end
            end
            D_BUSY: begin
                if (!MEM_BUSYWAIT) begin
                    if (mem_read_q) begin
                        dreaddata_d = MEM_READDATA;
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = D_DONE;
                end
            end
            I_BUSY: begin
                if (!MEM_BUSYWAIT) begin
                    ireaddata_d = MEM_READDATA;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = I_DONE;
                end
            end
            D_DONE:  state_d = IDLE;
            I_DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q         <= IDLE;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
            ireaddata_q     <= '0;
            dreaddata_q     <= '0;
        end else begin
            state_q         <= state_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
            ireaddata_q     <= ireaddata_d;
            dreaddata_q     <= dreaddata_d;
        end
    end

    // Stalls release only in the owner's DONE cycle.
    assign DBUSYWAIT     = d_req & (state_q != D_DONE);
    assign IBUSYWAIT     = IREAD & (state_q != I_DONE);

    assign MEM_READ      = mem_read_q;
    assign MEM_WRITE     = mem_write_q;
    assign MEM_ADDRESS   = mem_address_q;
    assign MEM_WRITEDATA = mem_writedata_q;
    assign IREADDATA     = ireaddata_q;
    assign DREADDATA     = dreaddata_q;

    a_strobe_excl: assert property (@(posedge CLK) disable iff (!RESET)
        !(mem_read_q && mem_write_q));

    a_strobe_idle: assert property (@(posedge CLK) disable iff (!RESET)
        (state_q == IDLE || state_q == D_DONE || state_q == I_DONE)
            |-> !(mem_read_q || mem_write_q));

endmodule
`default_nettype wire
